// File: rtl/bp_update_scheduler.sv
// Update scheduler for the branch predictor: buffers resolved-branch records from execute,
// drains them one per cycle around fetch-lookup index collisions, and sequences table clears.
module bp_update_scheduler #(
    parameter int QUEUE_DEPTH   = 4,
    parameter int TABLE_ENTRIES = 32,
    parameter int IDX_LSB       = 2,
    parameter int MAX_STALL     = 3
) (
    input  logic                             clk_g,
    input  logic                             rst_g,
    input  logic                             ex_upd_valid,
    output logic                             ex_upd_ready,
    input  logic [31:0]                      ex_upd_instr,
    input  logic [31:0]                      ex_upd_pc,
    input  logic                             ex_upd_taken,
    input  logic [31:0]                      ex_upd_target,
    input  logic                             ex_upd_mispredict,
    input  logic                             lookup_valid,
    input  logic [31:0]                      lookup_pc,
    input  logic                             clear_req,
    output logic                             bp_guncelle_gecerli,
    output logic [31:0]                      bp_eski_buyruk,
    output logic [31:0]                      bp_eski_buyruk_adresi,
    output logic                             bp_buyruk_atladi,
    output logic [31:0]                      bp_atlanan_adres,
    output logic                             bp_ongoru_yanlis,
    output logic                             bp_clear_valid,
    output logic [$clog2(TABLE_ENTRIES)-1:0] bp_clear_index,
    output logic                             init_done,
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy,
    output logic                             dbg_state
);

    localparam int IW = $clog2(TABLE_ENTRIES);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int SW = $clog2(MAX_STALL + 2);

    // Handshake: a record transfers on a rising clk_g edge where ex_upd_valid && ex_upd_ready;
    // ready never depends on valid, and valid must hold its record until it is taken.
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        mispredict;
    } upd_rec_t;

    upd_rec_t      mem_q [QUEUE_DEPTH];
    state_t        state_q, state_d;
    logic [IW-1:0] ctr_q, ctr_d;
    logic          started_q, started_d;
    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW:0]   count_q, count_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          upd_valid_q, upd_valid_d;
    upd_rec_t      out_q, out_d;

    upd_rec_t rec_in;
    upd_rec_t head;
    logic     full;
    logic     empty;
    logic     hazard;
    logic     ready;
    logic     do_enq;
    logic     do_issue;
    logic     unused_lookup_bits;

    assign unused_lookup_bits = ^lookup_pc;

    always_ff @(posedge clk_g or negedge rst_g) begin
        if (!rst_g) begin
            state_q     <= ST_INIT;
            ctr_q       <= '0;
            started_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= '0;
            upd_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            started_q   <= started_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
            upd_valid_q <= upd_valid_d;
            out_q       <= out_d;
        end
    end

    // Record storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk_g) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    always_comb begin
        rec_in   = '{instr: ex_upd_instr, pc: ex_upd_pc, taken: ex_upd_taken,
                     target: ex_upd_target, mispredict: ex_upd_mispredict};
        head     = mem_q[rd_ptr_q];
        full     = (count_q == (QW+1)'(QUEUE_DEPTH));
        empty    = (count_q == '0);
        hazard   = lookup_valid && (lookup_pc[IDX_LSB +: IW] == head.pc[IDX_LSB +: IW]);
        ready    = (state_q == ST_RUN) && !full && !clear_req;
        do_enq   = ex_upd_valid && ready;
        do_issue = (state_q == ST_RUN) && !empty && !clear_req &&
                   (!hazard || (stall_q == SW'(MAX_STALL)) || full);

        state_d     = state_q;
        ctr_d       = ctr_q;
        started_d   = 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + (QW+1)'(do_enq) - (QW+1)'(do_issue);
        upd_valid_d = do_issue;
        out_d       = out_q;
        stall_d     = stall_q;

        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            out_d    = head;
        end

        // A blocked head only counts stalls while it is actually waiting on a hazard.
        if (empty || do_issue || clear_req || (state_q != ST_RUN)) begin
            stall_d = '0;
        end else if (hazard) begin
            stall_d = stall_q + 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                if (clear_req) begin
                    ctr_d = '0;
                end else if (started_q) begin
                    if (ctr_q == IW'(TABLE_ENTRIES - 1)) begin
                        state_d = ST_RUN;
                        ctr_d   = '0;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d  = ST_INIT;
                    ctr_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ctr_d   = '0;
            end
        endcase
    end

    // The sweep begins on the first edge after reset release, so reset values hold until then.
    always_comb begin
        ex_upd_ready          = ready;
        bp_guncelle_gecerli   = upd_valid_q;
        bp_eski_buyruk        = out_q.instr;
        bp_eski_buyruk_adresi = out_q.pc;
        bp_buyruk_atladi      = out_q.taken;
        bp_atlanan_adres      = out_q.target;
        bp_ongoru_yanlis      = out_q.mispredict;
        bp_clear_valid        = (state_q == ST_INIT) && started_q;
        bp_clear_index        = ctr_q;
        init_done             = (state_q == ST_RUN);
        occupancy             = count_q;
        dbg_state             = state_q;
    end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
Sits between the execute stage and the branch predictor (dallanmaOngorucu) update port. Resolved-branch update records from execute are buffered in a small FIFO and drained into the predictor one per cycle. An issue is deferred when fetch is looking up the same table index in that cycle. After reset, or on request, the block sequences a full clear of the predictor table before accepting any updates.

Parameters:
QUEUE_DEPTH, 4, number of buffered update records (power of two, >=2)
TABLE_ENTRIES, 32, predictor table entries (power of two)
IDX_LSB, 2, lowest PC bit used for the table index
MAX_STALL, 3, consecutive hazard stalls after which the head is issued regardless

Ports:
clk_g  in  1  clock, rising edge
rst_g  in  1  asynchronous, active-low reset
ex_upd_valid  in  1  execute offers an update record
ex_upd_ready  out  1  scheduler accepts the record this cycle
ex_upd_instr  in  32  resolved branch instruction word
ex_upd_pc  in  32  resolved branch address
ex_upd_taken  in  1  branch actually taken
ex_upd_target  in  32  actual target address
ex_upd_mispredict  in  1  prediction was wrong
lookup_valid  in  1  fetch performs a predictor lookup this cycle
lookup_pc  in  32  fetch lookup address
clear_req  in  1  one-cycle pulse: discard queue and re-clear the table
bp_guncelle_gecerli  out  1  update strobe to the predictor
bp_eski_buyruk  out  32  to i_eski_buyruk
bp_eski_buyruk_adresi  out  32  to i_eski_buyruk_adresi
bp_buyruk_atladi  out  1  to i_buyruk_atladi
bp_atlanan_adres  out  32  to i_atlanan_adres
bp_ongoru_yanlis  out  1  to i_ongoru_yanlis
bp_clear_valid  out  1  clear-write strobe to the predictor table
bp_clear_index  out  log2(TABLE_ENTRIES)  table index being cleared
init_done  out  1  table clear complete; updates are flowing
occupancy  out  log2(QUEUE_DEPTH)+1  number of queued records

Behaviour:
- Index function: idx(pc) = pc[IDX_LSB +: log2(TABLE_ENTRIES)].
- Reset (rst_g=0, asynchronous):
  - All outputs are 0; bp_clear_index=0.
  - Queue is empty; stall counter=0; state=INIT.
- States:
  - INIT:
    - bp_clear_valid=1 and bp_clear_index=counter every cycle; the counter increments by 1 per cycle.
    - After index TABLE_ENTRIES-1 is driven, go to RUN next cycle. INIT therefore lasts exactly TABLE_ENTRIES cycles.
    - ex_upd_ready=0 and bp_guncelle_gecerli=0 throughout.
  - RUN:
    - init_done=1 and bp_clear_valid=0.
    - ex_upd_ready = !full && !clear_req, computed combinationally from the current count.
    - When full, ready=0 even if a dequeue happens in the same cycle.
- Enqueue: on ex_upd_valid && ex_upd_ready, all five fields are written at the tail.
- Issue decision, made each RUN cycle when the queue is non-empty:
  - hazard = lookup_valid && idx(lookup_pc)==idx(head.pc).
  - Issue when !hazard, or when stall_cnt==MAX_STALL, or when occupancy==QUEUE_DEPTH.
  - When a hazard blocks issue, stall_cnt increments; it resets to 0 on any issue or when the queue is empty.
- Issue action:
  - Dequeue the head and register its fields onto bp_*.
  - bp_guncelle_gecerli=1 for exactly the following cycle, then 0 unless another issue occurs.
  - Maximum throughput is 1 issue per cycle. Records leave in strict arrival order; mispredicts get no priority.
- Latency: a record accepted in cycle N into an empty queue, with no hazard, drives bp_guncelle_gecerli=1 in cycle N+2.
- Simultaneous enqueue and dequeue: both happen and occupancy is unchanged.
- clear_req in RUN:
  - Queue pointers and occupancy are reset to 0 and stall_cnt=0.
  - Any issue decided in the same cycle is suppressed.
  - Next cycle: state=INIT, counter=0, init_done=0, bp_guncelle_gecerli=0.
  - An issue already registered in the previous cycle still presents for its one cycle.
- clear_req in INIT: restarts the counter at 0 on the next cycle.
- Reset asserted mid-INIT or mid-drain: immediate return to the reset values; no partial update is held.
- bp_* data fields hold their last issued values when bp_guncelle_gecerli=0.

Test Plan:
1. Reset release with TABLE_ENTRIES=32 -> bp_clear_valid=1 for 32 cycles with bp_clear_index 0..31 in order; then init_done=1 and ex_upd_ready=1.
2. One record (pc=0x0000_0030, taken=1, target=0x0000_00A0, mispredict=1) accepted in cycle N with lookup_valid=0 -> bp_guncelle_gecerli=1 only in N+2, carrying bp_eski_buyruk_adresi=0x30, bp_atlanan_adres=0xA0, bp_ongoru_yanlis=1.
3. Five back-to-back valid records while lookup_valid=1 with lookup_pc always equal to each head's index -> ready=0 when occupancy=4, heads issue only after 3 stall cycles or when full, all 5 records emerge in order, none lost.
4. Queue holds 3 records and clear_req is pulsed -> occupancy=0 next cycle, none of the 3 appear on bp_*, and a full 32-cycle clear sweep follows.
5. Full queue with ex_upd_valid=1 and a dequeue in the same cycle -> ex_upd_ready=0 that cycle, occupancy drops to 3, and the offered record is accepted the next cycle.
6. rst_g pulled low mid-INIT at index 17 -> all outputs 0 immediately; after release the sweep restarts at index 0.
